output_ctrl: RTL
================

# output_ctrl

Clocked 2-to-1 output controller for the tree NoC router: the merge-side counterpart of the input controller's 1-to-2 split. It accepts packets from two upstream ports (the two child/sibling input controllers) over 4-phase req/ack bundled-data handshakes, buffers one packet per port, arbitrates between them, and forwards the winner on a single 4-phase output port toward the parent or next hop. Packets are forwarded unmodified; no routing decision is made here.

## Interface
- WIDTH_packet, 14, packet width in bits (bundled data)
- clk  input  1  clock; all handshake inputs are synchronous to it
- rst_n  input  1  asynchronous, active-low reset
- in1_req  input  1  port 1 request (4-phase)
- in1_data  input  WIDTH_packet  port 1 data, stable while in1_req=1
- in1_ack  output  1  port 1 acknowledge
- in2_req  input  1  port 2 request
- in2_data  input  WIDTH_packet  port 2 data
- in2_ack  output  1  port 2 acknowledge
- out_req  output  1  output request (4-phase)
- out_data  output  WIDTH_packet  output data, stable while out_req=1
- out_ack  input  1  output acknowledge from downstream

## Operation
- Per input port k: one-entry buffer buf_k with valid bit v_k, plus ack FSM.
  - Capture: in_k_req=1, in_k_ack=0, v_k=0 at an edge -> buf_k<=in_k_data, v_k<=1, in_k_ack<=1.
  - Return: in_k_req=0, in_k_ack=1 -> in_k_ack<=0.
  - No new capture while v_k=1 or in_k_ack=1.
- Output FSM, states IDLE, REQ, RET:
  - IDLE: if v1|v2, select winner w; out_data<=buf_w, v_w<=0, out_req<=1, go REQ. Otherwise stay.
  - REQ: on out_ack=1, out_req<=0, go RET.
  - RET: on out_ack=0, go IDLE.
- Arbitration (RR mode): last_grant register. Both valid -> grant the port not equal to last_grant. One valid -> grant it. last_grant<=w on every grant.
- v_k freed in IDLE and a capture on port k in the same edge: capture is evaluated against pre-edge v_k=1, so it is deferred one cycle. No packet is lost or duplicated.
- Data ordering is preserved per port. No ordering is guaranteed across ports.

## Timing
- Reset (async assert): in1_ack=0, in2_ack=0, out_req=0, out_data=0, v1=v2=0, state=IDLE, last_grant=port 2 (port 1 wins the first tie).
- Reset mid-operation: all in-flight packets are dropped immediately. After release, an in_k_req still held high is captured as a new packet. Senders must restart their handshake after reset.
- Latency: in_k_req sampled high at edge t -> in_k_ack=1 and v_k=1 after t. out_req=1 after edge t+1 (2 cycles, port idle, output FSM in IDLE).
- Output cycle: REQ->RET->IDLE takes at least 2 edges after out_ack rises. With a 1-cycle-responsive downstream, sustained throughput is 1 packet / 4 cycles.
- out_data changes only on the IDLE->REQ transition. It is held through REQ and RET.

## Configuration
- OUTPUT_CTRL_RR_EN defined: round-robin arbitration via last_grant as above.
- Undefined: fixed priority. Port 1 always wins when v1=v2=1, and last_grant is not implemented. Port 2 can starve under sustained port-1 traffic.

## Test plan
- Single packet: port 1 sends 14'h0A5; out_req rises 2 cycles after in1_req. Bench acks -> out_data=14'h0A5, in1_ack returns to 0 after in1_req drops.
- Simultaneous arrival with RR: both ports present at the same edge, in1=14'h111, in2=14'h222, from reset. Required output order: 0x111 then 0x222. Next tie grants port 1 again only after port 2 has been served.
- Fixed priority (macro off): continuous port-1 stream of 4 packets plus one pending port-2 packet -> all 4 port-1 packets precede port 2's.
- Backpressure: downstream withholds out_ack for 20 cycles. out_req and out_data stay stable; a second port-1 packet is captured, and a third stalls with in1_ack=0 until the output frees.
- Free/capture collision: a new port-1 request arrives the same edge the buffer is granted. The capture happens one cycle later; the output sequence shows no loss or duplicate.
- Reset mid-REQ: assert rst_n=0 while out_req=1. All outputs are 0 asynchronously; after release with requests idle, the FSM is in IDLE and the next packet passes normally.

Source files
------------

// File: rtl/output_ctrl.sv
// 2-to-1 output controller: two 4-phase input ports with one-entry buffers merged onto one 4-phase output.
// Define OUTPUT_CTRL_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module output_ctrl #(
    parameter int WIDTH_packet = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in1_req,
    input  logic [WIDTH_packet-1:0] in1_data,
    output logic                    in1_ack,
    input  logic                    in2_req,
    input  logic [WIDTH_packet-1:0] in2_data,
    output logic                    in2_ack,
    output logic                    out_req,
    output logic [WIDTH_packet-1:0] out_data,
    input  logic                    out_ack
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RET
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH_packet-1:0] buf1_q, buf1_d;
    logic [WIDTH_packet-1:0] buf2_q, buf2_d;
    logic                    v1_q, v1_d;
    logic                    v2_q, v2_d;
    logic                    ack1_q, ack1_d;
    logic                    ack2_q, ack2_d;
    logic                    out_req_q, out_req_d;
    logic [WIDTH_packet-1:0] out_data_q, out_data_d;
    logic                    prefer1;
    logic                    grant1;
`ifdef OUTPUT_CTRL_RR_EN
    logic                    last_grant_q, last_grant_d;
`endif

    always_comb begin
        state_d    = state_q;
        buf1_d     = buf1_q;
        buf2_d     = buf2_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        ack1_d     = ack1_q;
        ack2_d     = ack2_q;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
`ifdef OUTPUT_CTRL_RR_EN
        last_grant_d = last_grant_q;
        prefer1      = last_grant_q;
`else
        prefer1      = 1'b1;
`endif
        grant1 = v1_q && (!v2_q || prefer1);

        // Captures only look at pre-edge valid bits, so a buffer freed this edge refills next edge.
        if (in1_req && !ack1_q && !v1_q) begin
            buf1_d = in1_data;
            v1_d   = 1'b1;
            ack1_d = 1'b1;
        end else if (!in1_req && ack1_q) begin
            ack1_d = 1'b0;
        end

        if (in2_req && !ack2_q && !v2_q) begin
            buf2_d = in2_data;
            v2_d   = 1'b1;
            ack2_d = 1'b1;
        end else if (!in2_req && ack2_q) begin
            ack2_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (v1_q || v2_q) begin
                    if (grant1) begin
                        out_data_d = buf1_q;
                        v1_d       = 1'b0;
                    end else begin
                        out_data_d = buf2_q;
                        v2_d       = 1'b0;
                    end
`ifdef OUTPUT_CTRL_RR_EN
                    last_grant_d = !grant1;
`endif
                    out_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (out_ack) begin
                    out_req_d = 1'b0;
                    state_d   = RET;
                end
            end
            RET: begin
                if (!out_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_grant resets to port 2 so that port 1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf1_q     <= '0;
            buf2_q     <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            ack1_q     <= 1'b0;
            ack2_q     <= 1'b0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
`ifdef OUTPUT_CTRL_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            buf1_q     <= buf1_d;
            buf2_q     <= buf2_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            ack1_q     <= ack1_d;
            ack2_q     <= ack2_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
`ifdef OUTPUT_CTRL_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign in1_ack  = ack1_q;
    assign in2_ack  = ack2_q;
    assign out_req  = out_req_q;
    assign out_data = out_data_q;

endmodule
